// File: rtl/vga_pkg.sv
// Default 640x480@60 timing constants, derived totals and sync windows shared by
// the VGA timing generator and its counters.
package vga_pkg;

    localparam int CNT_W = 10;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    localparam int VGA_HS_START = VGA_H_ACTIVE + VGA_H_FP;
    localparam int VGA_HS_END   = VGA_HS_START + VGA_H_SYNC;
    localparam int VGA_VS_START = VGA_V_ACTIVE + VGA_V_FP;
    localparam int VGA_VS_END   = VGA_VS_START + VGA_V_SYNC;

    localparam logic [CNT_W-1:0] CNT_ZERO = 10'd0;
    localparam logic [CNT_W-1:0] CNT_ONE  = 10'd1;

    // Half-open window test lo <= cnt < hi
    function automatic logic in_window(input logic [CNT_W-1:0] cnt,
                                       input logic [CNT_W-1:0] lo,
                                       input logic [CNT_W-1:0] hi);
        return (cnt >= lo) && (cnt < hi);
    endfunction

endpackage

// File: rtl/vga_counter.sv
// 10-bit wrapping counter with enable; wrap pulses on the enabled cycle that
// holds the terminal value so it can chain into the next counter.
module vga_counter
    import vga_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [CNT_W-1:0] term,
    output logic [CNT_W-1:0] count,
    output logic             wrap
);

    assign wrap = en && (count == term);

    // Count register: clear on wrap, otherwise step when enabled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= CNT_ZERO;
        end else if (wrap) begin
            count <= CNT_ZERO;
        end else if (en) begin
            count <= count + CNT_ONE;
        end
    end

endmodule

// File: rtl/vga_controller.sv
// VGA timing generator: divides clk by two into a pixel tick, runs chained h/v
// counters and registers colour and active-low sync with a common 1-tick latency.
module vga_controller
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP
)(
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] pxl_x,
    output logic [31:0] pxl_y,
    input  logic [3:0]  red_in,
    input  logic [3:0]  green_in,
    input  logic [3:0]  blue_in,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        hsync,
    output logic        vsync,
    output logic        active,
    output logic        frame_start
);

    localparam logic [CNT_W-1:0] H_TERM = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CNT_W-1:0] V_TERM = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_LO  = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_HI  = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_LO  = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_HI  = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic             phase_r;
    logic             pixel_tick_s;
    logic [CNT_W-1:0] h_cnt_s;
    logic [CNT_W-1:0] v_cnt_s;
    logic             h_wrap_s;
    logic             v_wrap_s;
    logic             active_s;
    logic [11:0]      rgb_nxt_s;
    logic             hsync_nxt_s;
    logic             vsync_nxt_s;

    // Divide-by-two phase; the tick is high on every other clk edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_r <= 1'b0;
        end else begin
            phase_r <= ~phase_r;
        end
    end

    assign pixel_tick_s = phase_r;

    vga_counter u_h_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (pixel_tick_s),
        .term  (H_TERM),
        .count (h_cnt_s),
        .wrap  (h_wrap_s)
    );

    // The line carry advances v, so both wrap on the same tick at frame end
    vga_counter u_v_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (h_wrap_s),
        .term  (V_TERM),
        .count (v_cnt_s),
        .wrap  (v_wrap_s)
    );

    assign active_s    = (h_cnt_s < H_ACT) && (v_cnt_s < V_ACT);
    assign active      = active_s;
    assign pxl_x       = {{(32-CNT_W){1'b0}}, h_cnt_s};
    assign pxl_y       = {{(32-CNT_W){1'b0}}, v_cnt_s};
    assign frame_start = pixel_tick_s && (h_cnt_s == CNT_ZERO) && (v_cnt_s == CNT_ZERO);

    // Next colour and sync levels for the pixel the counters currently address
    always_comb begin
        rgb_nxt_s   = 12'h000;
        hsync_nxt_s = 1'b1;
        vsync_nxt_s = 1'b1;
        if (active_s) begin
            rgb_nxt_s = {red_in, green_in, blue_in};
        end else begin
            rgb_nxt_s = 12'h000;
        end
        hsync_nxt_s = !in_window(h_cnt_s, HS_LO, HS_HI);
        vsync_nxt_s = !in_window(v_cnt_s, VS_LO, VS_HI);
    end

    // Output registers, loaded once per pixel tick
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vga_r <= 4'h0;
            vga_g <= 4'h0;
            vga_b <= 4'h0;
            hsync <= 1'b1;
            vsync <= 1'b1;
        end else if (pixel_tick_s) begin
            vga_r <= rgb_nxt_s[11:8];
            vga_g <= rgb_nxt_s[7:4];
            vga_b <= rgb_nxt_s[3:0];
            hsync <= hsync_nxt_s;
            vsync <= vsync_nxt_s;
        end
    end

endmodule

// File: tb/tb_vga_controller.sv
// Directed bench: default-timing instance for line behaviour, plus a shrunken
// instance (15x8 totals) so whole frames fit in a short run.
module tb_vga_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  red_in = 4'h0, green_in = 4'h0, blue_in = 4'h0;

    logic [31:0] pxl_x, pxl_y;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic        hsync, vsync, active, frame_start;

    logic [31:0] pxl_x_s, pxl_y_s;
    logic [3:0]  vga_r_s, vga_g_s, vga_b_s;
    logic        hsync_s, vsync_s, active_s, frame_start_s;

    int n_checks = 0;
    int n_fail   = 0;

    always #10 clk = ~clk;

    vga_controller dut (
        .clk(clk), .reset(reset), .pxl_x(pxl_x), .pxl_y(pxl_y),
        .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .hsync(hsync), .vsync(vsync), .active(active), .frame_start(frame_start)
    );

    vga_controller #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) dut_s (
        .clk(clk), .reset(reset), .pxl_x(pxl_x_s), .pxl_y(pxl_y_s),
        .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
        .vga_r(vga_r_s), .vga_g(vga_g_s), .vga_b(vga_b_s),
        .hsync(hsync_s), .vsync(vsync_s), .active(active_s), .frame_start(frame_start_s)
    );

    typedef struct {
        int         adv;
        logic [3:0] r, g, b;
        int         ex, ey;
        logic [3:0] er, eg, eb;
        logic       ehs, evs, eact, efs;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Wait n rising edges, then sample at the following falling edge
    task automatic adv(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        adv(2);
        reset = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_fs, second_fs, lows, prev_x;
        logic prev_hs, seen_fall, seen_vfall, found;

        //          adv   r     g     b    x    y   er    eg    eb    hs    vs    act   fs
        vecs[0]  = '{1,    4'h5, 4'h6, 4'h7, 0,   0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[1]  = '{1,    4'h5, 4'h6, 4'h7, 1,   0, 4'h5, 4'h6, 4'h7, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{1277, 4'hF, 4'h0, 4'hA, 639, 0, 4'hF, 4'h0, 4'hA, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{1,    4'hF, 4'h0, 4'hA, 640, 0, 4'hF, 4'h0, 4'hA, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{2,    4'hF, 4'hF, 4'hF, 641, 0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{30,   4'hF, 4'hF, 4'hF, 656, 0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{2,    4'hF, 4'hF, 4'hF, 657, 0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{190,  4'hF, 4'hF, 4'hF, 752, 0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{2,    4'hF, 4'hF, 4'hF, 753, 0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{93,   4'hF, 4'hF, 4'hF, 799, 0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{1,    4'hF, 4'hF, 4'hF, 0,   1, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{1,    4'hF, 4'hF, 4'hF, 0,   1, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[12] = '{1,    4'h3, 4'hC, 4'h9, 1,   1, 4'h3, 4'hC, 4'h9, 1'b1, 1'b1, 1'b1, 1'b0};

        // Reset state while reset is held
        adv(3);
        check("rst.x", pxl_x, 32'd0);
        check("rst.y", pxl_y, 32'd0);
        check("rst.rgb", {vga_r, vga_g, vga_b}, 32'h000);
        check("rst.hs", hsync, 32'd1);
        check("rst.vs", vsync, 32'd1);
        check("rst.fs", frame_start, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 13; i++) begin
            red_in = vecs[i].r; green_in = vecs[i].g; blue_in = vecs[i].b;
            adv(vecs[i].adv);
            check($sformatf("v%0d.x", i), pxl_x, 32'(vecs[i].ex));
            check($sformatf("v%0d.y", i), pxl_y, 32'(vecs[i].ey));
            check($sformatf("v%0d.r", i), vga_r, 32'(vecs[i].er));
            check($sformatf("v%0d.g", i), vga_g, 32'(vecs[i].eg));
            check($sformatf("v%0d.b", i), vga_b, 32'(vecs[i].eb));
            check($sformatf("v%0d.hs", i), hsync, 32'(vecs[i].ehs));
            check($sformatf("v%0d.vs", i), vsync, 32'(vecs[i].evs));
            check($sformatf("v%0d.act", i), active, 32'(vecs[i].eact));
            check($sformatf("v%0d.fs", i), frame_start, 32'(vecs[i].efs));
        end

        // One full line of hsync: 96 ticks low, falling as x steps past 656
        lows = 0; prev_hs = hsync; seen_fall = 1'b0;
        for (int i = 0; i < 1600; i++) begin
            adv(1);
            if (hsync == 1'b0) lows++;
            if (prev_hs && !hsync && !seen_fall) begin
                seen_fall = 1'b1;
                check("hs.fall_x", pxl_x, 32'd657);
            end
            prev_hs = hsync;
        end
        check("hs.seen_fall", 32'(seen_fall), 32'd1);
        check("hs.low_clks", 32'(lows), 32'd192);

        // Shrunken frame: period, vsync width/position, vertical blanking of colour
        red_in = 4'hF; green_in = 4'h0; blue_in = 4'h0;
        do_reset();
        first_fs = -1; second_fs = -1; lows = 0; prev_x = -1; seen_vfall = 1'b0;
        for (int i = 1; i <= 600; i++) begin
            adv(1);
            if (frame_start_s) begin
                if (first_fs < 0) first_fs = i;
                else if (second_fs < 0) second_fs = i;
            end
            if (i <= 240) begin
                if (!vsync_s) lows++;
                if (!vsync_s && !seen_vfall) begin
                    seen_vfall = 1'b1;
                    check("vs.fall_y", pxl_y_s, 32'd5);
                    check("vs.fall_x", pxl_x_s, 32'd1);
                end
                if (pxl_x_s == 32'd1 && prev_x != 1)
                    check($sformatf("vline%0d.r", pxl_y_s), vga_r_s,
                          (pxl_y_s < 32'd4) ? 32'hF : 32'h0);
            end
            prev_x = int'(pxl_x_s);
        end
        check("fs.first", 32'(first_fs), 32'd1);
        check("fs.period", 32'(second_fs - first_fs), 32'd240);
        check("vs.low_clks", 32'(lows), 32'd60);

        // Asynchronous reset mid-line at (300,1)
        red_in = 4'hF; green_in = 4'hF; blue_in = 4'hF;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 5000 && !found; i++) begin
            adv(1);
            if (pxl_x == 32'd300 && pxl_y == 32'd1) found = 1'b1;
        end
        check("ar.found", 32'(found), 32'd1);
        check("ar.pre_r", vga_r, 32'hF);
        #3 reset = 1'b1;
        #1;
        check("ar.x", pxl_x, 32'd0);
        check("ar.y", pxl_y, 32'd0);
        check("ar.rgb", {vga_r, vga_g, vga_b}, 32'h000);
        check("ar.hs", hsync, 32'd1);
        check("ar.vs", vsync, 32'd1);
        check("ar.fs", frame_start, 32'd0);
        check("ar.s_xy", {pxl_x_s[15:0], pxl_y_s[15:0]}, 32'd0);
        check("ar.s_sync", {hsync_s, vsync_s}, 32'd3);
        adv(2);
        reset = 1'b0;
        adv(1);
        check("ar.e1_x", pxl_x, 32'd0);
        check("ar.e1_fs", frame_start, 32'd1);
        adv(1);
        check("ar.e2_x", pxl_x, 32'd1);
        check("ar.e2_y", pxl_y, 32'd0);
        check("ar.e2_fs", frame_start, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_controller.md
VGA_CONTROLLER -- requirements
Module: vga_controller

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 Parameter H_FP, default 16, horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, default 96, hsync pulse width in pixels.
REQ-004 Parameter H_BP, default 48, horizontal back porch in pixels; line total = 800 at defaults.
REQ-005 Parameter V_ACTIVE, default 480, visible lines per frame.
REQ-006 Parameter V_FP, default 10, vertical front porch in lines.
REQ-007 Parameter V_SYNC, default 2, vsync pulse width in lines.
REQ-008 Parameter V_BP, default 33, vertical back porch in lines; frame total = 525 at defaults.
REQ-009 clk  input  1  50 MHz system clock, the only clock.
REQ-010 reset  input  1  asynchronous, active-high reset.
REQ-011 pxl_x  output  32  current horizontal count, 0..799, zero-extended; feeds the background and object units.
REQ-012 pxl_y  output  32  current vertical count, 0..524, zero-extended.
REQ-013 red_in / green_in / blue_in  input  4 each  pixel colour returned combinationally by the background/object path for the current pxl_x/pxl_y.
REQ-014 vga_r / vga_g / vga_b  output  4 each  registered colour to the DAC pins.
REQ-015 hsync / vsync  output  1 each  registered sync outputs, active-low.
REQ-016 active  output  1  high while pxl_x < H_ACTIVE and pxl_y < V_ACTIVE, combinational from the counters.
REQ-017 frame_start  output  1  one-clk pulse marking the start of a frame.

Function
REQ-018 A phase bit SHALL toggle on every clk edge; pixel_tick = phase; all counters and registered outputs SHALL update only on edges where pixel_tick = 1 (25 MHz pixel rate).
REQ-019 h_cnt SHALL increment per tick and wrap from line total - 1 to 0; v_cnt SHALL increment only on an h_cnt wrap and wrap from frame total - 1 to 0 on the same tick that h_cnt wraps.
REQ-020 pxl_x and pxl_y SHALL equal h_cnt and v_cnt directly, with zero latency.
REQ-021 On each tick, vga_r/g/b SHALL register the *_in value if active is 1, else 0; latency is 1 pixel tick relative to pxl_x/pxl_y.
REQ-022 On each tick, hsync SHALL register 0 iff H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751), else 1.
REQ-023 On each tick, vsync SHALL register 0 iff V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (490..491), else 1; sync and colour SHALL therefore share the same 1-tick latency.
REQ-024 frame_start SHALL be 1 for exactly one clk cycle, when h_cnt = 0, v_cnt = 0 and pixel_tick = 1; it is 0 at all other times.
REQ-025 Input colour outside the active region SHALL never reach vga_r/g/b.
REQ-026 Counter widths SHALL be 10 bits internally; arithmetic SHALL not overflow at defaults.

Reset
REQ-027 While reset = 1: phase = 0, h_cnt = 0, v_cnt = 0, vga_r/g/b = 0, hsync = 1, vsync = 1, frame_start = 0.
REQ-028 Reset asserted mid-frame SHALL force the REQ-027 values immediately, without waiting for a clk edge.
REQ-029 After release, the first clk edge SHALL set phase = 1 and the second clk edge SHALL advance h_cnt to 1.

Structure
REQ-030 Package vga_pkg SHALL hold the default timing constants and derived line and frame totals, plus the sync-window bounds.
REQ-031 Sub-module vga_counter SHALL implement a 10-bit wrap counter with enable, terminal value and a carry/wrap output; it SHALL be instantiated twice, once for h and once for v, with the h carry enabling v.

Verification
REQ-032 Release reset -> hsync = vsync = 1, vga_r/g/b = 0, frame_start pulses on clk edge 2, and pxl_x = 1 after clk edge 2.
REQ-033 Run 1600 clk -> pxl_x = 0, pxl_y = 1; hsync low for exactly 192 clk per line, falling one tick after pxl_x = 656.
REQ-034 Run a full frame -> frame_start period = 840000 clk; vsync low for exactly 3200 clk, starting one tick after pxl_y = 490.
REQ-035 Hold red_in = 4'hF -> vga_r = F on the tick after pxl_x = 639, and vga_r = 0 on the tick after pxl_x = 640 and after pxl_y = 480.
REQ-036 Assert reset asynchronously at pxl_x = 300, pxl_y = 100 -> all outputs reach REQ-027 values before the next clk edge; after release, the count restarts at 0,0.
